// File: rtl/fsm_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fsm_counter_arbiter
// Description : Round-robin arbiter that shares one fsm_counter among NREQ
//               requesters. The winner's count is issued to the counter with
//               a single run pulse. The winner is acked when the counter
//               reports done, or when the watchdog expires (err=1).
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_counter_arbiter #(
  parameter int NREQ    = 4,     // number of requesters (2..8)
  parameter int TIMEOUT = 1024,  // max WAIT cycles before abort, 0 = no watchdog
  parameter int TW      = 16     // watchdog counter width, TIMEOUT < 2**TW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_count,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 cnt_run,
  output logic [31:0]          cnt_in_count,
  input  logic                 cnt_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_ACK   = 2'd3;

  // Watchdog only exists when TIMEOUT is non-zero; the limit is the last
  // timer value tolerated in WAIT before the job is aborted.
  localparam bit            c_WD_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] c_TLIM    = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [2:0]    c_LAST_RST = 3'(NREQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [2:0]      r_last_grant;
  logic [2:0]      r_grant_id;
  logic [31:0]     r_cnt_in_count;
  logic [TW-1:0]   r_timer;
  logic [NREQ-1:0] r_ack;
  logic            r_err;
  logic            r_busy;
  logic            r_cnt_run;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic            w_found;
  logic [2:0]      w_pick;
  logic [31:0]     w_pick_count;
  int              w_dist;
  int              w_best;
  logic [1:0]      w_next;
  logic            w_timeout_hit;
  logic [2:0]      w_ack_grant;
  logic [NREQ-1:0] w_ack_vec;

  // Round-robin pick: the requester closest after r_last_grant (wrapping) wins.
  // Distance 0 is the slot right after the last winner, so the last winner
  // itself has the lowest priority.
  always_comb begin
    w_found      = 1'b0;
    w_pick       = r_last_grant;
    w_pick_count = '0;
    w_best       = NREQ;
    w_dist       = 0;
    for (int j = 0; j < NREQ; j++) begin
      w_dist = j - int'(r_last_grant) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + NREQ;
      end
      if (req[j] && (w_dist < w_best)) begin
        w_best       = w_dist;
        w_found      = 1'b1;
        w_pick       = 3'(j);
        w_pick_count = req_count[32*j +: 32];
      end
    end
  end

  // Next-state decode; also flags a watchdog abort on the WAIT->ACK edge.
  always_comb begin
    w_next        = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_found) begin
          // A zero-length job is acknowledged without ever starting the counter.
          w_next = (w_pick_count == 32'd0) ? c_ST_ACK : c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        w_next = c_ST_WAIT;
      end
      c_ST_WAIT: begin
        if (cnt_done) begin
          w_next = c_ST_ACK;
        end else if (c_WD_EN && (r_timer == c_TLIM)) begin
          w_next        = c_ST_ACK;
          w_timeout_hit = 1'b1;
        end
      end
      c_ST_ACK: begin
        w_next = c_ST_IDLE;
      end
      default: begin
        w_next = c_ST_IDLE;
      end
    endcase
  end

  // One-hot ack for the requester that will own the ACK cycle. On the
  // zero-count shortcut the grant is being made in this very cycle, so the
  // fresh pick is used instead of the registered grant.
  always_comb begin
    w_ack_grant = (r_state == c_ST_IDLE) ? w_pick : r_grant_id;
    w_ack_vec   = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_ack_vec[j] = (w_ack_grant == 3'(j));
    end
  end

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------

  // FSM state and the outputs that are pure functions of the next state,
  // registered so they line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_busy    <= 1'b0;
      r_cnt_run <= 1'b0;
      r_ack     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != c_ST_IDLE);
      r_cnt_run <= (w_next == c_ST_ISSUE);
      r_ack     <= (w_next == c_ST_ACK) ? w_ack_vec : '0;
      r_err     <= (w_next == c_ST_ACK) && w_timeout_hit;
    end
  end

  // Grant capture: id and count are frozen from grant until the next grant,
  // so the counter input never moves while a job is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_id     <= 3'd0;
      r_cnt_in_count <= 32'd0;
    end else if ((r_state == c_ST_IDLE) && w_found) begin
      r_grant_id     <= w_pick;
      r_cnt_in_count <= w_pick_count;
    end
  end

  // Rotation pointer advances only when a job is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= c_LAST_RST;
    end else if (r_state == c_ST_ACK) begin
      r_last_grant <= r_grant_id;
    end
  end

  // Watchdog timer: cleared while issuing, counts WAIT cycles, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state == c_ST_ISSUE) begin
      r_timer <= '0;
    end else if ((r_state == c_ST_WAIT) && (r_timer != '1)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ack          = r_ack;
  assign err          = r_err;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;
  assign cnt_run      = r_cnt_run;
  assign cnt_in_count = r_cnt_in_count;

endmodule
`default_nettype wire

// File: tb/tb_fsm_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_counter_arbiter
// Description : Self-checking bench for fsm_counter_arbiter with a behavioural
//               counter and a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_counter_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int TW      = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0;
  logic [127:0]  req_count = '0;
  logic [3:0]    ack;
  logic          err;
  logic          busy;
  logic [2:0]    grant_id;
  logic          cnt_run;
  logic [31:0]   cnt_in_count;
  logic          cnt_done;

  int errors = 0;
  int checks = 0;
  int model_last = NREQ - 1;
  int cnts [4];
  int run_pulses = 0;

  // Behavioural counter: done pulses 'count' cycles after the run pulse.
  int unsigned rem;
  bit          never_done = 1'b0;
  bit          stray = 1'b0;

  fsm_counter_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_count(req_count),
    .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
    .cnt_run(cnt_run), .cnt_in_count(cnt_in_count), .cnt_done(cnt_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem <= 0;
    else if (cnt_run === 1'b1) rem <= cnt_in_count;
    else if (rem != 0) rem <= rem - 1;
  end

  assign cnt_done = ((rem == 1) && !never_done) || stray;

  always @(posedge clk) begin
    if (cnt_run === 1'b1) run_pulses <= run_pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang, want finish");
    $fatal(1);
  end

  // Reference round-robin: first requester after 'last', wrapping.
  function automatic int next_winner(input int last, input logic [3:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_counts();
    for (int i = 0; i < NREQ; i++) req_count[32*i +: 32] = 32'(cnts[i]);
  endtask

  // Post 'mask' from an IDLE cycle and follow one job through to its ack.
  task automatic do_job(input logic [3:0] mask, input bit exp_to);
    int w; int c; int n; int runs0; bit moved; logic [3:0] oh;
    w = next_winner(model_last, mask);
    c = cnts[w];
    oh = 4'(1 << w);
    runs0 = run_pulses;
    req = mask;
    step();
    checks++;
    if (grant_id !== 3'(w)) begin errors++; $display("FAIL grant_id: got %0d want %0d", grant_id, w); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_at_grant: got %b want 1", busy); end
    if (c == 0) begin
      checks++;
      if (ack !== oh) begin errors++; $display("FAIL zero_ack: got %b want %b", ack, oh); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", err); end
    end else begin
      checks++;
      if (cnt_run !== 1'b1) begin errors++; $display("FAIL run_pulse: got %b want 1", cnt_run); end
      checks++;
      if (cnt_in_count !== 32'(c)) begin errors++; $display("FAIL in_count: got %0d want %0d", cnt_in_count, c); end
      checks++;
      if (ack !== 4'b0) begin errors++; $display("FAIL early_ack: got %b want 0000", ack); end
      n = 0;
      moved = 1'b0;
      while (ack === 4'b0 && n < 300) begin
        step();
        n++;
        if (cnt_in_count !== 32'(c)) moved = 1'b1;
      end
      checks++;
      if (n != (exp_to ? TIMEOUT + 1 : c + 1)) begin
        errors++; $display("FAIL ack_latency: got %0d want %0d", n, exp_to ? TIMEOUT + 1 : c + 1);
      end
      checks++;
      if (moved) begin errors++; $display("FAIL in_count_hold: got changed want %0d held", c); end
      checks++;
      if (ack !== oh) begin errors++; $display("FAIL ack_vec: got %b want %b", ack, oh); end
      checks++;
      if (err !== exp_to) begin errors++; $display("FAIL err_flag: got %b want %b", err, exp_to); end
    end
    model_last = w;
    step();
    checks++;
    if (ack !== 4'b0) begin errors++; $display("FAIL ack_single: got %b want 0000", ack); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after: busy got %b want 0", busy); end
    checks++;
    if (run_pulses - runs0 != ((c == 0) ? 0 : 1)) begin
      errors++; $display("FAIL run_count: got %0d want %0d", run_pulses - runs0, (c == 0) ? 0 : 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({ack, err, busy, grant_id, cnt_run, cnt_in_count} !== '0) begin
      errors++;
      $display("FAIL %s: ack=%b err=%b busy=%b gid=%0d run=%b cnt=%0d want all 0",
               tag, ack, err, busy, grant_id, cnt_run, cnt_in_count);
    end
  endtask

  task automatic test_reset();
    step(); step();
    check_all_zero("reset_state");
    rst_n = 1'b1;
    // Start a long job and yank reset while it sits in WAIT.
    cnts = '{0, 0, 50, 0};
    apply_counts();
    req = 4'b0100;
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_wait");
    req = 4'b0;
    step();
    rst_n = 1'b1;
    model_last = NREQ - 1;
    step();
    check_all_zero("reset_no_ack");
    cnts = '{2, 2, 2, 2};
    apply_counts();
    do_job(4'b1111, 1'b0);
    checks++;
    if (model_last != 0) begin errors++; $display("FAIL first_grant: got %0d want 0", model_last); end
    req = 4'b0;
  endtask

  task automatic test_single();
    cnts = '{1, 1, 10, 1};
    apply_counts();
    do_job(4'b0100, 1'b0);
    req = 4'b0;
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_last = NREQ - 1;
    cnts = '{3, 5, 7, 9};
    apply_counts();
    for (int i = 0; i < 5; i++) begin
      do_job(4'b1111, 1'b0);
      checks++;
      if (grant_id !== 3'(order[i])) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_id, order[i]);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_zero_count();
    cnts = '{4, 0, 4, 4};
    apply_counts();
    do_job(4'b0010, 1'b0);
    req = 4'b0;
  endtask

  task automatic test_timeout();
    bit bad;
    never_done = 1'b1;
    cnts = '{1, 1, 1, 100};
    apply_counts();
    do_job(4'b1000, 1'b1);
    req = 4'b0;
    // Let the counter's late done arrive while the arbiter is idle.
    never_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ack !== 4'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL late_done: got ack/busy activity want none"); end
  endtask

  task automatic test_stray_done();
    req = 4'b0;
    stray = 1'b1;
    step();
    stray = 1'b0;
    checks++;
    if (ack !== 4'b0) begin errors++; $display("FAIL stray_ack: got %b want 0000", ack); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stray_busy: got %b want 0", busy); end
    step();
    checks++;
    if (busy !== 1'b0 || cnt_run !== 1'b0) begin
      errors++; $display("FAIL stray_idle: busy=%b run=%b want 0 0", busy, cnt_run);
    end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    for (int j = 0; j < 24; j++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) cnts[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      apply_counts();
      do_job(mask, 1'b0);
    end
    req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_zero_count();
    test_timeout();
    test_stray_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
